// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REL_DB
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } snap_class_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // first stage may go metastable; only the second stage is used downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
   parameter int SCAN_DIV       = 1024,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   import keypad_pkg::*;

   localparam int DIV_W    = $clog2(SCAN_DIV);
   localparam int COL_W    = $clog2(NUM_COLS);
   localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
   localparam int BC_W     = $clog2(NUM_KEYS + 1);

   logic [NUM_ROWS-1:0] row_sync;
   logic [DIV_W-1:0]    div_q;
   logic [COL_W-1:0]    col_q;
   logic [COL_W-1:0]    col_next;
   logic                sample_en;
   logic                scan_done;
   logic [NUM_KEYS-1:0] snap_q;
   logic [NUM_KEYS-1:0] snap_eval;
   logic [BC_W-1:0]     bit_cnt;
   logic [KEY_W-1:0]    cls_key;
   snap_class_t         snap_class;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d, n_sat;
   logic [KEY_W-1:0]    cand_q, cand_d;
   logic                accept;
   logic                release_done;
   logic [KEY_W-1:0]    key_code_d;
   logic                key_valid_d;
   logic                key_held_d;

   // rows idle high through the pull-ups, so the synchronizer resets to "no key"
   sync_2ff #(
      .WIDTH     (NUM_ROWS),
      .RESET_VAL ({NUM_ROWS{1'b1}})
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_in),
      .q     (row_sync)
   );

   assign sample_en = (div_q == DIV_W'(SCAN_DIV - 1));
   assign scan_done = sample_en && (col_q == COL_W'(NUM_COLS - 1));
   assign col_next  = col_q + COL_W'(1);

   // divider and column counter; column drive is registered so it never glitches
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q   <= '0;
         col_q   <= '0;
         col_out <= 4'b1110;
      end else if (sample_en) begin
         div_q   <= '0;
         col_q   <= col_next;
         col_out <= ~(4'b0001 << col_next);
      end else begin
         div_q   <= div_q + DIV_W'(1);
      end
   end

   // snapshot with the current column merged in, so scan completion sees column 3
   always_comb begin
      snap_eval = snap_q;
      snap_eval[int'(col_q) * NUM_ROWS +: NUM_ROWS] = ~row_sync;
   end

   // keep the per-column samples for the rest of the scan
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_q <= '0;
      end else if (sample_en) begin
         snap_q <= snap_eval;
      end
   end

   // count pressed positions; snapshot bit c*4+r maps to key code r*4+c
   always_comb begin
      bit_cnt = '0;
      cls_key = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (snap_eval[i]) begin
            bit_cnt = bit_cnt + BC_W'(1);
            cls_key = KEY_W'((i % NUM_ROWS) * NUM_COLS + i / NUM_ROWS);
         end
      end
      if (bit_cnt == BC_W'(0)) begin
         snap_class = NONE;
      end else if (bit_cnt == BC_W'(1)) begin
         snap_class = SINGLE;
      end else begin
         snap_class = MULTI;
      end
   end

   assign n_sat = (n_q == CNT_W'(DEBOUNCE_SCANS)) ? n_q : n_q + CNT_W'(1);

   // debounce state, match counter and candidate key
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cand_q  <= cand_d;
      end
   end

   // next-state: only a completed scan can move the debounce machine
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      cand_d       = cand_q;
      accept       = 1'b0;
      release_done = 1'b0;
      if (scan_done) begin
         case (state_q)
            IDLE: begin
               if (snap_class == SINGLE) begin
                  cand_d = cls_key;
                  n_d    = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept  = 1'b1;
                     state_d = HELD;
                  end else begin
                     state_d = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (snap_class != SINGLE) begin
                  state_d = IDLE;
               end else if (cls_key == cand_q) begin
                  n_d = n_sat;
                  if (n_sat == CNT_W'(DEBOUNCE_SCANS)) begin
                     accept  = 1'b1;
                     state_d = HELD;
                  end
               end else begin
                  cand_d = cls_key;
                  n_d    = CNT_W'(1);
               end
            end
            HELD: begin
               if (snap_class == NONE) begin
                  n_d = CNT_W'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     release_done = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     state_d = REL_DB;
                  end
               end
            end
            REL_DB: begin
               if (snap_class == NONE) begin
                  n_d = n_sat;
                  if (n_sat == CNT_W'(DEBOUNCE_SCANS)) begin
                     release_done = 1'b1;
                     state_d      = IDLE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // output decode: key_code only ever changes on an accept
   always_comb begin
      key_code_d  = accept ? cand_d : key_code;
      key_valid_d = accept;
      if (accept) begin
         key_held_d = 1'b1;
      end else if (release_done) begin
         key_held_d = 1'b0;
      end else begin
         key_held_d = key_held;
      end
   end

   // registered key event outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_code  <= key_code_d;
         key_valid <= key_valid_d;
         key_held  <= key_held_d;
      end
   end

endmodule
